// File: rtl/keypad_decoder.sv
// Keypad decoder: synchronises the row/column pair, checks that exactly one key is down,
// debounces press and release, and emits a key code with one-cycle press/release strobes.
module keypad_decoder #(
  parameter int DB_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  input  logic [3:0] kpc,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    r1, r2, c1, c2;
  logic [3:0]    cand_r, cand_c;
  logic [CW-1:0] cnt;
  logic          single;
  logic          match;
  logic          rows_idle;

  // Columns take the same two-flop path as rows so the sampled pair stays coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1 <= 4'hF;
      r2 <= 4'hF;
      c1 <= 4'hF;
      c2 <= 4'hF;
    end else begin
      r1 <= kpr;
      r2 <= r1;
      c1 <= kpc;
      c2 <= c1;
    end
  end

  function automatic logic one_low(input logic [3:0] v);
    return (v == 4'b0111) || (v == 4'b1011) || (v == 4'b1101) || (v == 4'b1110);
  endfunction

  function automatic logic [1:0] idx(input logic [3:0] v);
    case (v)
      4'b0111: return 2'd0;
      4'b1011: return 2'd1;
      4'b1101: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Row 0 is the top row (kpr[3]); column 0 is the leftmost (kpc[3]).
  function automatic logic [3:0] decode(input logic [3:0] r, input logic [3:0] c);
    case ({idx(r), idx(c)})
      4'd0:    return 4'd1;
      4'd1:    return 4'd2;
      4'd2:    return 4'd3;
      4'd3:    return 4'd10;
      4'd4:    return 4'd4;
      4'd5:    return 4'd5;
      4'd6:    return 4'd6;
      4'd7:    return 4'd11;
      4'd8:    return 4'd7;
      4'd9:    return 4'd8;
      4'd10:   return 4'd9;
      4'd11:   return 4'd12;
      4'd12:   return 4'd14;
      4'd13:   return 4'd0;
      4'd14:   return 4'd15;
      default: return 4'd13;
    endcase
  endfunction

  assign single    = one_low(r2) && one_low(c2);
  assign match     = (r2 == cand_r) && (c2 == cand_c);
  assign rows_idle = (r2 == 4'hF);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cand_r      <= 4'hF;
      cand_c      <= 4'hF;
      cnt         <= '0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (single) begin
            cand_r <= r2;
            cand_c <= c2;
            cnt    <= '0;
            state  <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            state <= IDLE;
          end else if (cnt == TERM) begin
            state     <= PRESSED;
            key_code  <= decode(cand_r, cand_c);
            key_valid <= 1'b1;
            key_held  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          // Roll-over onto a second key is ignored; only all rows high starts a release.
          if (rows_idle) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!rows_idle) begin
            cnt   <= '0;
            state <= PRESSED;
          end else if (cnt == TERM) begin
            state       <= IDLE;
            key_held    <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder with DB_CYCLES=4: press/release latency, bounce,
// multi-key rejection, release bounce, reset abort and a full key-map sweep.
module tb_keypad_decoder;

  localparam int DB = 4;

  logic       clk;
  logic       reset_n;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_release;
  logic [1:0] dbg_state;

  int n_vec;
  int n_mis;
  int n_valid;
  int n_release;
  int n_both;
  int v0;
  int r0;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  logic [3:0] map_tbl [16];

  keypad_decoder #(.DB_CYCLES(DB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .kpr         (kpr),
    .kpc         (kpc),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (key_valid) begin
      n_valid++;
      got_q.push_back(key_code);
    end
    if (key_release) n_release++;
    if (key_valid && key_release) n_both++;
  end

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver: press a key, expect its strobe after DB+3 edges
  task automatic press_expect(input logic [3:0] r, input logic [3:0] c, input logic [3:0] code,
                              input string tag);
    kpr = r;
    kpc = c;
    step(DB + 2);
    check_vec({tag, "_early"}, 16'(key_valid), 16'd0);
    step(1);
    check_vec({tag, "_valid"}, 16'(key_valid), 16'd1);
    check_vec({tag, "_code"}, 16'(key_code), 16'(code));
    check_vec({tag, "_held"}, 16'(key_held), 16'd1);
    step(1);
    check_vec({tag, "_pulse1"}, 16'(key_valid), 16'd0);
  endtask

  task automatic release_expect(input string tag);
    kpr = 4'hF;
    step(DB + 2);
    check_vec({tag, "_rel_early"}, 16'(key_release), 16'd0);
    check_vec({tag, "_held_on"}, 16'(key_held), 16'd1);
    step(1);
    check_vec({tag, "_release"}, 16'(key_release), 16'd1);
    check_vec({tag, "_held_off"}, 16'(key_held), 16'd0);
    step(1);
    check_vec({tag, "_rel_pulse1"}, 16'(key_release), 16'd0);
  endtask

  initial begin
    n_vec = 0; n_mis = 0; n_valid = 0; n_release = 0; n_both = 0;
    map_tbl = '{4'd1, 4'd2, 4'd3, 4'd10, 4'd4, 4'd5, 4'd6, 4'd11,
                4'd7, 4'd8, 4'd9, 4'd12, 4'd14, 4'd0, 4'd15, 4'd13};
    reset_n = 1'b0;
    kpr = 4'hF;
    kpc = 4'hF;
    step(3);
    check_vec("rst_code", 16'(key_code), 16'd0);
    check_vec("rst_flags", 16'({key_valid, key_held, key_release}), 16'd0);
    check_vec("rst_state", 16'(dbg_state), 16'd0);
    reset_n = 1'b1;
    step(2);

    // clean press of "5", held 20 cycles, then released
    v0 = n_valid;
    press_expect(4'b1011, 4'b1011, 4'd5, "k5");
    step(12);
    check_vec("k5_held_long", 16'(key_held), 16'd1);
    check_vec("k5_one_valid", 16'(n_valid - v0), 16'd1);
    release_expect("k5");
    check_vec("k5_code_kept", 16'(key_code), 16'd5);
    step(2);

    // bouncing "#": 2-cycle runs never accepted
    v0 = n_valid;
    kpc = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      kpr = (i % 2 == 0) ? 4'b1110 : 4'hF;
      step(2);
    end
    step(4);
    check_vec("bounce_no_valid", 16'(n_valid - v0), 16'd0);
    press_expect(4'b1110, 4'b1101, 4'd15, "khash");
    check_vec("khash_one_valid", 16'(n_valid - v0), 16'd1);
    release_expect("khash");
    step(2);

    // two keys in one column are rejected
    v0 = n_valid;
    kpc = 4'b1011;
    kpr = 4'b1001;
    step(20);
    check_vec("multi_no_valid", 16'(n_valid - v0), 16'd0);
    check_vec("multi_idle", 16'(dbg_state), 16'd0);
    kpr = 4'hF;
    step(3);

    // release bounce on "A"
    press_expect(4'b0111, 4'b1110, 4'd10, "ka");
    step(5);
    r0 = n_release;
    kpr = 4'hF;
    step(2);
    kpr = 4'b0111;
    step(8);
    check_vec("ka_no_release", 16'(n_release - r0), 16'd0);
    check_vec("ka_still_held", 16'(key_held), 16'd1);
    release_expect("ka");
    check_vec("ka_one_release", 16'(n_release - r0), 16'd1);
    step(2);

    // reset two cycles into the debounce of "0", key kept down
    kpr = 4'b1110;
    kpc = 4'b1011;
    step(5);
    check_vec("k0_in_debounce", 16'(dbg_state), 16'd1);
    reset_n = 1'b0;
    #1;
    check_vec("k0_rst_code", 16'(key_code), 16'd0);
    check_vec("k0_rst_flags", 16'({key_valid, key_held, key_release}), 16'd0);
    check_vec("k0_rst_state", 16'(dbg_state), 16'd0);
    step(2);
    reset_n = 1'b1;
    press_expect(4'b1110, 4'b1011, 4'd0, "k0");
    release_expect("k0");
    step(2);

    // full key-map sweep, column held on the pressed key
    got_q.delete();
    exp_q.delete();
    r0 = n_release;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(map_tbl[k]);
      kpr = ~(4'b1000 >> (k / 4));
      kpc = ~(4'b1000 >> (k % 4));
      step(DB + 4);
      kpr = 4'hF;
      step(DB + 4);
    end
    check_vec("sweep_count", 16'(got_q.size()), 16'd16);
    check_vec("sweep_releases", 16'(n_release - r0), 16'd16);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_vec("sweep_code", 16'(got_q.pop_front()), 16'(exp_q.pop_front()));
    check_vec("sweep_missing", 16'(exp_q.size()), 16'd0);
    check_vec("no_coincident_strobes", 16'(n_both), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
